p4_controller: RTL

P4_CONTROLLER -- requirements
Module: p4_controller

---
 rtl/p4_controller.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/p4_controller.sv
// Instruction-sequencing controller for a simple 16-bit datapath (IR, decode FSM, Moore control outputs).
// Optional illegal-instruction trap state is enabled by defining P4_CTRL_ILLEGAL_TRAP_EN.
//
// state       | meaning
// ST_WAIT     | idle, w=1, IR may be loaded, s starts execution
// ST_DECODE   | classify the held instruction, no enables
// ST_WRITE_IMM| write sximm8 into Rn
// ST_GET_A    | read Rn into A
// ST_GET_B    | read Rm into B
// ST_OPERATE  | ALU step: load C (or status for CMP)
// ST_WRITE_REG| write C into Rd
// ST_ERR      | illegal instruction trapped, held until reset (trap build only)
module p4_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic        err,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_DECODE,
    ST_WRITE_IMM,
    ST_GET_A,
    ST_GET_B,
    ST_OPERATE,
    ST_WRITE_REG
`ifdef P4_CTRL_ILLEGAL_TRAP_EN
    , ST_ERR
`endif
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;

  logic [2:0] w_opcode;
  logic [1:0] w_op;
  logic [2:0] w_rn;
  logic [2:0] w_rd;
  logic [2:0] w_rm;
  logic       w_is_movimm;
  logic       w_is_movreg;
  logic       w_is_alu;
  logic       w_is_mvn;
  logic       w_is_cmp;

  assign w_opcode = r_ir[15:13];
  assign w_op     = r_ir[12:11];
  assign w_rn     = r_ir[10:8];
  assign w_rd     = r_ir[7:5];
  assign w_rm     = r_ir[2:0];

  assign shift  = r_ir[4:3];
  assign ALUop  = w_op;
  assign sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};
  assign sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};

  assign w_is_movimm = (w_opcode == 3'b110) && (w_op == 2'b10);
  assign w_is_movreg = (w_opcode == 3'b110) && (w_op == 2'b00);
  assign w_is_alu    = (w_opcode == 3'b101);
  assign w_is_mvn    = w_is_alu && (w_op == 2'b11);
  assign w_is_cmp    = w_is_alu && (w_op == 2'b01);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_WAIT;
      r_ir    <= 16'h0000;
    end else begin
      r_state <= w_next;
      // IR is only writable while idle so an in-flight instruction cannot be corrupted
      if ((r_state == ST_WAIT) && load) r_ir <= in;
    end
  end

  always_comb begin
    w_next   = r_state;
    w        = 1'b0;
    err      = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 2'b00;
    case (r_state)
      ST_WAIT: begin
        w = 1'b1;
        if (s) w_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (w_is_movimm)                 w_next = ST_WRITE_IMM;
        else if (w_is_movreg || w_is_mvn) w_next = ST_GET_B;
        else if (w_is_alu)               w_next = ST_GET_A;
        else begin
`ifdef P4_CTRL_ILLEGAL_TRAP_EN
          w_next = ST_ERR;
`else
          w_next = ST_WAIT;
`endif
        end
      end
      ST_WRITE_IMM: begin
        writenum = w_rn;
        vsel     = 2'b10;
        write    = 1'b1;
        w_next   = ST_WAIT;
      end
      ST_GET_A: begin
        readnum = w_rn;
        loada   = 1'b1;
        w_next  = ST_GET_B;
      end
      ST_GET_B: begin
        readnum = w_rm;
        loadb   = 1'b1;
        w_next  = ST_OPERATE;
      end
      ST_OPERATE: begin
        asel = w_is_movreg || w_is_mvn;
        if (w_is_cmp) begin
          loads  = 1'b1;
          w_next = ST_WAIT;
        end else begin
          loadc  = 1'b1;
          w_next = ST_WRITE_REG;
        end
      end
      ST_WRITE_REG: begin
        writenum = w_rd;
        vsel     = 2'b00;
        write    = 1'b1;
        w_next   = ST_WAIT;
      end
`ifdef P4_CTRL_ILLEGAL_TRAP_EN
      ST_ERR: begin
        err    = 1'b1;
        w_next = ST_ERR;
      end
`endif
      default: w_next = ST_WAIT;
    endcase
  end

endmodule
